// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: opcode constants, the canonical nop and the fetch FSM states.
// HALT exists only when FETCH_MISALIGN_TRAP_EN is defined.
package rv32i_pkg;

    localparam logic [6:0]  OP_LW     = 7'd3;
    localparam logic [6:0]  OP_SW     = 7'd35;
    localparam logic [6:0]  OP_R      = 7'd51;
    localparam logic [6:0]  OP_B      = 7'd99;
    localparam logic [6:0]  OP_I      = 7'd19;
    localparam logic [6:0]  OP_JAL    = 7'd111;
    localparam logic [6:0]  OP_JALR   = 7'd103;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        HALT = 2'd3
`endif
    } fetchState_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selector: sequential pc+4 or word-aligned redirect target.
// FETCH_MISALIGN_TRAP_EN adds detection of a redirect to a non-word-aligned target.
module pc_next (
    input  logic [31:0] pc,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic [31:0] nextPc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misTarget
`endif
);

    // Low target bits are dropped; in the trap build a misaligned target never reaches pc anyway.
    assign nextPc = pcSrc ? (pcTarget & ~32'd3) : (pc + 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misTarget = pcSrc && (pcTarget[1:0] != 2'b00);
`endif

endmodule

// File: rtl/fetch_unit.sv
// rv32i instruction fetch: PC register, req/ack fetch FSM and the held instruction for decode.
// FETCH_MISALIGN_TRAP_EN enables the sticky misalign flag and the HALT state.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    input  logic        stall,
    input  logic        pcSrc,
    input  logic [31:0] pcTarget,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [31:0] pcOut,
    output logic [31:0] pcPlus4,
    output logic        instrValid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign
`endif
);

    fetchState_t state, nextState;
    logic [31:0] pc;
    logic [31:0] nextPc;
    logic        consume;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misTarget;
`endif

    pc_next uPcNext (
        .pc       (pc),
        .pcSrc    (pcSrc),
        .pcTarget (pcTarget),
        .nextPc   (nextPc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misTarget(misTarget)
`endif
    );

    assign imemAddr = pc;
    assign op       = instr[6:0];
    assign pcPlus4  = pcOut + 32'd4;
    assign consume  = (state == HOLD) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState  = state;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        case (state)
            IDLE: nextState = REQ;
            REQ: begin
                imemReq = 1'b1;
                if (imemAck) nextState = HOLD;
            end
            HOLD: begin
                instrValid = 1'b1;
                if (!stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    nextState = misTarget ? HALT : REQ;
`else
                    nextState = REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            HALT: nextState = HALT;
`endif
            default: nextState = IDLE;
        endcase
    end

    // pcOut is captured with the instruction so it keeps naming the held word after pc moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instr    <= NOP_INSTR;
            pcOut    <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
        end else begin
            if (state == REQ && imemAck) begin
                instr <= imemRdata;
                pcOut <= pc;
            end
            if (consume) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (misTarget) misalign <= 1'b1;
                else           pc       <= nextPc;
`else
                pc <= nextPc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, reset corner cases, random traffic.
// Honours FETCH_MISALIGN_TRAP_EN the same way as the design.
module tb_fetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic        stall;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pcOut;
    logic [31:0] pcPlus4;
    logic        instrValid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imemReq   (imemReq),
        .imemAddr  (imemAddr),
        .imemAck   (imemAck),
        .imemRdata (imemRdata),
        .stall     (stall),
        .pcSrc     (pcSrc),
        .pcTarget  (pcTarget),
        .instr     (instr),
        .op        (op),
        .pcOut     (pcOut),
        .pcPlus4   (pcPlus4),
        .instrValid(instrValid)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        pcSrc;
        logic [31:0] tgt;
        logic        expReq;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expInstr;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(logic ack, logic [31:0] rdata, logic stl, logic src,
                                   logic [31:0] tgt, logic eReq, logic [31:0] eAddr,
                                   logic eValid, logic [31:0] eInstr, logic [31:0] ePc);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stall = stl; v.pcSrc = src; v.tgt = tgt;
        v.expReq = eReq; v.expAddr = eAddr; v.expValid = eValid;
        v.expInstr = eInstr; v.expPc = ePc;
        return v;
    endfunction

    // Instruction memory contents used by the random phase.
    function automatic logic [31:0] memWord(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        imemAck   = v.ack;
        imemRdata = v.rdata;
        stall     = v.stall;
        pcSrc     = v.pcSrc;
        pcTarget  = v.tgt;
    endtask

    task automatic checkAll(input string tag, input logic eReq, input logic [31:0] eAddr,
                            input logic eValid, input logic [31:0] eInstr, input logic [31:0] ePc);
        logic [31:0] e4;
        e4 = ePc + 32'd4;
        checkOutput({tag, " imemReq"}, {31'd0, imemReq}, {31'd0, eReq});
        checkOutput({tag, " imemAddr"}, imemAddr, eAddr);
        checkOutput({tag, " instrValid"}, {31'd0, instrValid}, {31'd0, eValid});
        checkOutput({tag, " instr"}, instr, eInstr);
        checkOutput({tag, " op"}, {25'd0, op}, {25'd0, eInstr[6:0]});
        checkOutput({tag, " pcOut"}, pcOut, ePc);
        checkOutput({tag, " pcPlus4"}, pcPlus4, e4);
    endtask

    task automatic idleInputs();
        imemAck = 1'b0; imemRdata = 32'd0; stall = 1'b0; pcSrc = 1'b0; pcTarget = 32'd0;
    endtask

    // Random-phase reference: tracks which phase the fetch transaction is in and what it must show.
    logic        mReq, mValid;
    logic [31:0] mAddr, mInstr, mPc;

    initial begin
        logic [31:0] r;
        logic        nReq, nValid;

        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, RESET_PC, 1'b0, NOP_INSTR, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("reset misalign", {31'd0, misalign}, 32'd0);
`endif

        vecs.push_back(mkVec(0, 0,            0, 0, 0,            0, 0,            0, NOP_INSTR,    0));
        vecs.push_back(mkVec(1, 32'h3,        0, 0, 0,            1, 0,            0, NOP_INSTR,    0));
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            0, 0,            1, 32'h3,        0));
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            1, 4,            0, 32'h3,        0));
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            1, 4,            0, 32'h3,        0));
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            1, 4,            0, 32'h3,        0));
        vecs.push_back(mkVec(1, 32'h00A00093, 0, 0, 0,            1, 4,            0, 32'h3,        0));
        vecs.push_back(mkVec(0, 0,            1, 1, 32'h40,       0, 4,            1, 32'h00A00093, 4));
        vecs.push_back(mkVec(0, 0,            1, 0, 32'h40,       0, 4,            1, 32'h00A00093, 4));
        vecs.push_back(mkVec(1, 32'hFFFFFFFF, 1, 1, 32'h40,       0, 4,            1, 32'h00A00093, 4));
        vecs.push_back(mkVec(0, 0,            1, 0, 32'h40,       0, 4,            1, 32'h00A00093, 4));
        vecs.push_back(mkVec(0, 0,            1, 1, 32'h40,       0, 4,            1, 32'h00A00093, 4));
        vecs.push_back(mkVec(0, 0,            0, 0, 32'h40,       0, 4,            1, 32'h00A00093, 4));
        vecs.push_back(mkVec(1, 32'h0080006F, 0, 0, 0,            1, 8,            0, 32'h00A00093, 4));
        vecs.push_back(mkVec(0, 0,            0, 1, 32'h100,      0, 8,            1, 32'h0080006F, 8));
        vecs.push_back(mkVec(1, 32'h33,       0, 0, 0,            1, 32'h100,      0, 32'h0080006F, 8));
        vecs.push_back(mkVec(0, 0,            0, 1, 32'hFFFFFFFC, 0, 32'h100,      1, 32'h33,       32'h100));
        vecs.push_back(mkVec(1, 32'h63,       0, 0, 0,            1, 32'hFFFFFFFC, 0, 32'h33,       32'h100));
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            0, 32'hFFFFFFFC, 1, 32'h63,       32'hFFFFFFFC));
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            1, 0,            0, 32'h63,       32'hFFFFFFFC));
        vecs.push_back(mkVec(1, 32'h2003,     0, 0, 0,            1, 0,            0, 32'h63,       32'hFFFFFFFC));
        vecs.push_back(mkVec(0, 0,            0, 1, 32'h102,      0, 0,            1, 32'h2003,     0));
`ifdef FETCH_MISALIGN_TRAP_EN
        vecs.push_back(mkVec(1, 32'h13,       0, 0, 0,            0, 0,            0, 32'h2003,     0));
`else
        vecs.push_back(mkVec(0, 0,            0, 0, 0,            1, 32'h100,      0, 32'h2003,     0));
`endif

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkAll($sformatf("row%0d", i), vecs[i].expReq, vecs[i].expAddr,
                     vecs[i].expValid, vecs[i].expInstr, vecs[i].expPc);
            @(posedge clk);
            #1;
        end

`ifdef FETCH_MISALIGN_TRAP_EN
        // Halted: no request or valid whatever the inputs do, until reset.
        for (int i = 0; i < 4; i++) begin
            imemAck = 1'b1; stall = 1'b0; pcSrc = 1'b1; pcTarget = 32'h200;
            @(negedge clk);
            checkOutput("halt imemReq", {31'd0, imemReq}, 32'd0);
            checkOutput("halt instrValid", {31'd0, instrValid}, 32'd0);
            checkOutput("halt misalign", {31'd0, misalign}, 32'd1);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("halt reset misalign", {31'd0, misalign}, 32'd0);
        @(posedge clk);
        #1;
        idleInputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("halt recover imemReq", {31'd0, imemReq}, 32'd1);
        checkOutput("halt recover imemAddr", imemAddr, RESET_PC);
`endif

        // Reset in the middle of a request, then a late ack arriving while IDLE.
        idleInputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset pre imemReq", {31'd0, imemReq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset imemReq", {31'd0, imemReq}, 32'd0);
        checkOutput("midreset imemAddr", imemAddr, RESET_PC);
        imemAck = 1'b1;
        imemRdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkAll("lateack", 1'b0, RESET_PC, 1'b0, NOP_INSTR, RESET_PC);
        @(posedge clk);
        #1;
        imemAck = 1'b0;
        @(negedge clk);
        checkAll("afterlate", 1'b1, RESET_PC, 1'b0, NOP_INSTR, RESET_PC);

        // Random traffic: DUT sits in a request for RESET_PC with no ack this cycle.
        mReq = 1'b1; mValid = 1'b0; mAddr = RESET_PC; mInstr = NOP_INSTR; mPc = RESET_PC;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            imemAck   = ($urandom_range(0, 1) == 1);
            imemRdata = imemAck ? memWord(imemAddr) : $urandom;
            stall     = ($urandom_range(0, 2) == 0);
            pcSrc     = ($urandom_range(0, 3) == 0);
            r         = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            pcTarget  = {r[31:2], 2'b00};
`else
            pcTarget  = r;
`endif
            @(negedge clk);
            checkOutput("rand imemReq", {31'd0, imemReq}, {31'd0, mReq});
            checkOutput("rand instrValid", {31'd0, instrValid}, {31'd0, mValid});
            if (mReq) checkOutput("rand imemAddr", imemAddr, mAddr);
            if (mValid) checkAll("rand hold", 1'b0, mPc, 1'b1, mInstr, mPc);

            nReq = mReq;
            nValid = mValid;
            if (mReq && imemAck) begin
                mInstr = memWord(mAddr);
                mPc    = mAddr;
                nReq   = 1'b0;
                nValid = 1'b1;
            end
            if (mValid && !stall) begin
                mAddr  = pcSrc ? {pcTarget[31:2], 2'b00} : mPc + 32'd4;
                nValid = 1'b0;
                nReq   = 1'b1;
            end
            mReq = nReq;
            mValid = nValid;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        checkOutput("rand misalign", {31'd0, misalign}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
